// File: rtl/qft_run_ctrl.sv
// Launch-and-capture controller for the pipelined 3-qubit QFT core.
// Optional overrun flag logic is built only when QFT_RUN_CTRL_OVERRUN_EN is defined.
module qft_run_ctrl #(
  parameter int PIPE_LAT = 4,
  parameter int W        = 6,
  parameter int NEL      = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               clear,
  input  logic [NEL*W-1:0]   spi_in_vec,
  output logic [NEL*W-1:0]   core_in_vec,
  input  logic [NEL*W-1:0]   core_out_vec,
  output logic [NEL*W-1:0]   res_vec,
  output logic               busy,
  output logic               done,
  output logic               overrun
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_CAP  = 2'd2
  } state_t;

  localparam logic [7:0] LAST_CNT = 8'(PIPE_LAT - 1);

  state_t             r_state;
  logic [7:0]         r_cnt;
  logic [NEL*W-1:0]   r_core_in;
  logic [NEL*W-1:0]   r_res;
  logic               r_busy;
  logic               r_done;

  // clear is applied first so the CAP edge can still raise done in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_core_in <= '0;
      r_res     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      if (clear) r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_core_in <= spi_in_vec;
            r_cnt     <= '0;
            r_busy    <= 1'b1;
            r_done    <= 1'b0;
            r_state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt + 8'd1;
          if (r_cnt == LAST_CNT) r_state <= S_CAP;
        end
        S_CAP: begin
          r_res   <= core_out_vec;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef QFT_RUN_CTRL_OVERRUN_EN
  logic r_overrun;

  // a start while a launch is in flight is dropped but remembered here
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overrun <= 1'b0;
    end else if (clear) begin
      r_overrun <= 1'b0;
    end else if (start && (r_state != S_IDLE)) begin
      r_overrun <= 1'b1;
    end
  end

  assign overrun = r_overrun;
`else
  assign overrun = 1'b0;
`endif

  assign core_in_vec = r_core_in;
  assign res_vec     = r_res;
  assign busy        = r_busy;
  assign done        = r_done;

endmodule

// File: tb/tb_qft_run_ctrl.sv
// Directed bench for qft_run_ctrl with an identity QFT core model of PIPE_LAT cycles.
module tb_qft_run_ctrl;
  localparam int PIPE_LAT = 4;
  localparam int W        = 6;
  localparam int NEL      = 16;
  localparam int VW       = NEL * W;
`ifdef QFT_RUN_CTRL_OVERRUN_EN
  localparam logic OV_EXP = 1'b1;
`else
  localparam logic OV_EXP = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          clear;
  logic [VW-1:0] spi_in_vec;
  logic [VW-1:0] core_in_vec;
  logic [VW-1:0] core_out_vec;
  logic [VW-1:0] res_vec;
  logic          busy;
  logic          done;
  logic          overrun;

  logic [VW-1:0] pipe [PIPE_LAT];
  logic          out_ovr;
  logic [VW-1:0] exp_core;
  logic [VW-1:0] exp_res;
  int            total;
  int            bad;

  qft_run_ctrl #(.PIPE_LAT(PIPE_LAT), .W(W), .NEL(NEL)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .clear        (clear),
    .spi_in_vec   (spi_in_vec),
    .core_in_vec  (core_in_vec),
    .core_out_vec (core_out_vec),
    .res_vec      (res_vec),
    .busy         (busy),
    .done         (done),
    .overrun      (overrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // identity core: output is the input delayed PIPE_LAT cycles
  always @(posedge clk) begin
    pipe[0] <= core_in_vec;
    for (int i = 1; i < PIPE_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign core_out_vec = out_ovr ? {VW{1'b1}} : pipe[PIPE_LAT-1];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_core_in"}, core_in_vec, '0);
    chk({tag, "_res"}, res_vec, '0);
    chk({tag, "_busy"}, VW'(busy), '0);
    chk({tag, "_done"}, VW'(done), '0);
    chk({tag, "_overrun"}, VW'(overrun), '0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    // reset with every input driven nonzero
    rst_n      = 1'b0;
    start      = 1'b1;
    clear      = 1'b1;
    out_ovr    = 1'b1;
    spi_in_vec = {VW{1'b1}};
    for (int i = 0; i < PIPE_LAT; i++) pipe[i] = '0;
    step();
    step();
    chk_zero("rst_during");
    start      = 1'b0;
    clear      = 1'b0;
    out_ovr    = 1'b0;
    spi_in_vec = '0;
    rst_n      = 1'b1;
    step();
    chk_zero("rst_after");

    // first launch: element 0 = 05, element 15 = 3A
    spi_in_vec[0*W +: W]  = 6'h05;
    spi_in_vec[15*W +: W] = 6'h3A;
    exp_core = spi_in_vec;
    start = 1'b1;
    step();                                   // E0
    start = 1'b0;
    chk("l1_core_in", core_in_vec, exp_core);
    chk("l1_busy_e0", VW'(busy), VW'(1));
    spi_in_vec[3*W +: W] = 6'h11;             // change while busy
    for (int c = 1; c <= PIPE_LAT; c++) begin
      step();
      chk("l1_busy", VW'(busy), VW'(1));
      chk("l1_done_low", VW'(done), '0);
      chk("l1_core_in_hold", core_in_vec, exp_core);
      chk("l1_res_hold", res_vec, '0);
    end
    step();                                   // E0+5
    exp_res = exp_core;
    chk("l1_busy_end", VW'(busy), '0);
    chk("l1_done", VW'(done), VW'(1));
    chk("l1_res", res_vec, exp_res);

    // second launch with a start during WAIT
    exp_core = spi_in_vec;                    // now includes element 3 = 11
    start = 1'b1;
    step();                                   // E0
    start = 1'b0;
    chk("l2_core_in", core_in_vec, exp_core);
    chk("l2_done_cleared", VW'(done), '0);
    step();                                   // E0+1
    start = 1'b1;
    step();                                   // E0+2
    start = 1'b0;
    chk("l2_overrun", VW'(overrun), VW'(OV_EXP));
    chk("l2_busy", VW'(busy), VW'(1));
    step();
    step();                                   // E0+4
    chk("l2_done_low", VW'(done), '0);
    chk("l2_res_prev", res_vec, exp_res);
    step();                                   // E0+5
    exp_res = exp_core;
    chk("l2_done", VW'(done), VW'(1));
    chk("l2_busy_end", VW'(busy), '0);
    chk("l2_res", res_vec, exp_res);
    step();
    chk("l2_no_relaunch", VW'(busy), '0);
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("clr_overrun", VW'(overrun), '0);
    chk("clr_done", VW'(done), '0);
    chk("clr_res_kept", res_vec, exp_res);

    // reset in the middle of a launch
    spi_in_vec[1*W +: W] = 6'h2A;
    start = 1'b1;
    step();                                   // E0
    start = 1'b0;
    step();
    step();
    step();                                   // E0+3
    #2 rst_n = 1'b0;
    #1;
    chk_zero("rst_mid");
    #1 rst_n = 1'b1;
    step();
    chk_zero("rst_mid_after");
    exp_core = spi_in_vec;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("l3_core_in", core_in_vec, exp_core);
    for (int c = 1; c <= PIPE_LAT; c++) begin
      step();
      chk("l3_busy", VW'(busy), VW'(1));
    end
    step();
    chk("l3_done", VW'(done), VW'(1));
    chk("l3_res", res_vec, exp_core);

    // clear and start together in IDLE with done set
    spi_in_vec[7*W +: W] = 6'h3F;
    exp_core = spi_in_vec;
    clear = 1'b1;
    start = 1'b1;
    step();
    clear = 1'b0;
    start = 1'b0;
    chk("l4_done_low", VW'(done), '0);
    chk("l4_overrun", VW'(overrun), '0);
    chk("l4_busy", VW'(busy), VW'(1));
    chk("l4_core_in", core_in_vec, exp_core);
    for (int c = 1; c <= PIPE_LAT; c++) step();
    chk("l4_done_pre", VW'(done), '0);
    step();
    chk("l4_done", VW'(done), VW'(1));
    chk("l4_busy_end", VW'(busy), '0);
    chk("l4_res", res_vec, exp_core);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/qft_run_ctrl.md
# qft_run_ctrl

Launch-and-capture controller between the SPI register bank and the pipelined 3-qubit QFT core. On a start pulse it snapshots the 16 SPI-written operand registers into stable core inputs. It then waits the core's fixed pipeline latency and latches the 16 core outputs into holding registers that the SPI block reads back. Busy, done and overrun flags let firmware poll completion over SPI.

## Interface
- PIPE_LAT, 4, QFT core pipeline latency in clk cycles; legal range 1–255
- W, `TOTAL_WIDTH (6), element width from fixed_point_params.vh
- NEL, 16, number of operand/result elements (8 complex, r/i interleaved); fixed
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- start  in  1  launch request, sampled each clk edge; single-cycle pulse expected
- clear  in  1  clears done and overrun
- spi_in_vec  in  NEL*W  operands from SPI bank; element k at [k*W +: W], k = SPI write address 0x00–0x0F
- core_in_vec  out  NEL*W  operands driven to QFT core; held stable between launches
- core_out_vec  in  NEL*W  QFT core outputs, same element ordering
- res_vec  out  NEL*W  captured results to SPI read ports; element k serves read address 0x10+k
- busy  out  1  launch in progress
- done  out  1  sticky result-valid flag
- overrun  out  1  sticky: start seen while busy

## Operation
- Reset values: core_in_vec=0, res_vec=0, busy=0, done=0, overrun=0, state=IDLE, cnt=0.
- States:
  - IDLE: start=1 → core_in_vec<=spi_in_vec, cnt<=0, busy<=1, done<=0 → WAIT.
  - WAIT: cnt increments each cycle; when cnt==PIPE_LAT-1 → CAP.
  - CAP: res_vec<=core_out_vec (all 16 elements same edge), done<=1, busy<=0 → IDLE.
- core_in_vec changes only on the IDLE→WAIT edge; res_vec changes only on the CAP edge.
- Elements pass bit-exact; no arithmetic, sign extension or truncation. cnt is 8 bits and never wraps at legal PIPE_LAT.
- start in WAIT or CAP: ignored for launch; sets overrun (see Configuration).
- clear: done<=0, overrun<=0; does not abort a launch or touch res_vec.
- Simultaneous events:
  - clear and start in IDLE: launch proceeds; done=0, overrun=0.
  - clear in CAP: done=1 wins; overrun cleared.
  - start in CAP: ignored; does not relaunch.
- Reset mid-launch: immediate return to all reset values; no partial capture.
- res_vec keeps the previous result until the next CAP edge, including while busy.

## Timing
- start sampled high at edge E0 (IDLE) → core_in_vec, busy=1 visible after E0.
- CAP at edge E0+PIPE_LAT+1 → res_vec, done=1, busy=0 visible after it.
- Launch-to-done latency: PIPE_LAT+1 cycles. busy is high for exactly PIPE_LAT+1 cycles.
- Earliest next launch: start sampled at edge E0+PIPE_LAT+2.
- Core outputs are sampled once, at the CAP edge only.

## Configuration
- QFT_RUN_CTRL_OVERRUN_EN defined: overrun sets on any start sampled in WAIT or CAP and stays set until clear or reset.
- QFT_RUN_CTRL_OVERRUN_EN undefined: overrun is tied to 0 and no flag logic is built. A start while busy is still ignored.

## Test plan
- Reset with W=6, PIPE_LAT=4, all inputs nonzero → core_in_vec, res_vec, busy, done, overrun all 0 during and after reset.
- Element 0=6'h05, element 15=6'h3A, others 0; start at E0; core model = identity, 4-cycle delay → core_in_vec loaded after E0; busy high 5 cycles; done=1 after E0+5; res_vec element 0=6'h05, element 15=6'h3A.
- Start again at E0+2 during the first launch → no relaunch; done still after E0+5; overrun=1 with macro, 0 without; clear → overrun=0.
- Change spi_in_vec element 3 to 6'h11 while busy → core_in_vec element 3 unchanged until the next launch.
- rst_n low at E0+3 mid-launch, released → all outputs 0, state IDLE; fresh start completes normally after PIPE_LAT+1 cycles.
- clear and start in the same IDLE cycle with done=1 → done=0 next cycle, launch completes, done=1 after PIPE_LAT+1 cycles.
